// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC and the shared instruction-memory
// port, arbitrating between CPU fetch and the program-loader write channel.
module fetch_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_pc,
  input  logic              i_stop,
  input  logic              i_branch_valid,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_load_req,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_instruction,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_inst_valid,
  output logic              o_halted
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] f_q, tag_q, skid_pc_q, pc_q;
  logic [DATA_W-1:0] skid_data_q, instr_q;
  logic              ret_q, skid_vld_q, vld_q;

  logic              run_s, issue_s, load_s, deliver_s;
  logic [DATA_W-1:0] next_word_s;
  logic [ADDR_W-1:0] next_pc_s;

  function automatic logic is_halt(input logic [DATA_W-1:0] w);
    return (w[DATA_W-1 -: 4] == 4'hF);
  endfunction

  // Issue/load decisions; skid content takes precedence over a fresh return.
  always_comb begin
    run_s       = (state_q == S_RUN);
    issue_s     = run_s && !i_stop && !i_branch_valid;
    load_s      = !run_s && i_load_req;
    deliver_s   = issue_s && (skid_vld_q || ret_q);
    next_word_s = skid_vld_q ? skid_data_q : i_mem_rdata;
    next_pc_s   = skid_vld_q ? skid_pc_q : tag_q;
  end

  // The memory port is combinational; reset forces it quiet so no write can slip through.
  assign o_mem_re      = i_reset && issue_s;
  assign o_mem_we      = i_reset && load_s;
  assign o_load_ack    = i_reset && load_s;
  assign o_mem_wdata   = (i_reset && load_s) ? i_load_data : {DATA_W{1'b0}};
  assign o_mem_addr    = !i_reset ? {ADDR_W{1'b0}} :
                         load_s   ? i_load_addr    :
                         issue_s  ? f_q            : {ADDR_W{1'b0}};
  assign o_instruction = instr_q;
  assign o_pc          = pc_q;
  assign o_inst_valid  = vld_q;
  assign o_halted      = (state_q == S_HALT);

  // Sequencer state, fetch PC, in-flight tag, skid buffer and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      f_q         <= ADDR_W'(RESET_PC);
      tag_q       <= {ADDR_W{1'b0}};
      ret_q       <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= {DATA_W{1'b0}};
      skid_pc_q   <= {ADDR_W{1'b0}};
      instr_q     <= {DATA_W{1'b0}};
      pc_q        <= {ADDR_W{1'b0}};
      vld_q       <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (i_branch_valid) begin
            f_q        <= i_branch_target;
            ret_q      <= 1'b0;
            skid_vld_q <= 1'b0;
            vld_q      <= 1'b0;
          end else if (i_stop) begin
            ret_q <= 1'b0;
            if (ret_q) begin
              skid_vld_q  <= 1'b1;
              skid_data_q <= i_mem_rdata;
              skid_pc_q   <= tag_q;
            end
          end else begin
            f_q        <= f_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            tag_q      <= f_q;
            ret_q      <= 1'b1;
            skid_vld_q <= 1'b0;
            vld_q      <= deliver_s;
            if (deliver_s) begin
              instr_q <= next_word_s;
              pc_q    <= next_pc_s;
              // The read issued alongside the HALT word is dropped by HALT itself.
              if (is_halt(next_word_s)) begin
                state_q <= S_HALT;
              end
            end
          end
        end
        S_IDLE, S_HALT: begin
          ret_q <= 1'b0;
          if (state_q == S_HALT && !i_stop) begin
            vld_q <= 1'b0;
          end
          if (!i_load_req && i_start) begin
            f_q        <= i_start_pc;
            vld_q      <= 1'b0;
            skid_vld_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
